// File: rtl/diffeq_mul_sched.sv
// rtl/diffeq_mul_sched.sv - diffeq loop scheduler sharing one external multiplier
// Optional iteration limit: define DIFFEQ_ITER_LIMIT_EN.
module diffeq_mul_sched #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 0,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 200
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [WIDTH-1:0]     dx_in,
    input  logic [WIDTH-1:0]     u_in,
    input  logic [WIDTH-1:0]     y_in,
    input  logic [WIDTH-1:0]     a_in,
    output logic                 mul_req,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_ack,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     x_out,
    output logic [WIDTH-1:0]     y_out,
    output logic [WIDTH-1:0]     u_out,
    output logic [ITER_W-1:0]    iter_count,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL0   = 3'd1,
        S_MUL1   = 3'd2,
        S_MUL2   = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state, next_state;

    logic signed [WIDTH-1:0] x_r, dx_r, u_r, y_r, a_r;
    logic signed [WIDTH-1:0] p0, p1, p2;
    logic        [ITER_W-1:0] iter_r;

    logic signed [WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] x_next, u_next, y_next;
    logic        [ITER_W-1:0] iter_next;
    logic                    loop_more;
    logic                    limit_hit;
    logic                    unused_mul_p;

    assign prod         = mul_p[FRAC+WIDTH-1:FRAC];
    assign unused_mul_p = ^mul_p;

    // 3*v is formed as (v<<1)+v; everything wraps modulo 2^WIDTH.
    assign x_next    = x_r + dx_r;
    assign y_next    = y_r + p0;
    assign u_next    = u_r - ((p1 <<< 1) + p1) - ((p2 <<< 1) + p2);
    assign iter_next = iter_r + 1'b1;
    assign loop_more = x_next < a_r;

`ifdef DIFFEQ_ITER_LIMIT_EN
    logic err_r;
    assign limit_hit = (iter_next == ITER_W'(MAX_ITER));
    assign err       = err_r;
`else
    localparam int unused_max_iter = MAX_ITER;
    assign limit_hit = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        mul_req    = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    next_state = ($signed(x_in) < $signed(a_in)) ? S_MUL0 : S_DONE;
            end
            S_MUL0: begin
                mul_req = 1'b1;
                mul_a   = u_r;
                mul_b   = dx_r;
                if (mul_ack) next_state = S_MUL1;
            end
            S_MUL1: begin
                mul_req = 1'b1;
                mul_a   = x_r;
                mul_b   = p0;
                if (mul_ack) next_state = S_MUL2;
            end
            S_MUL2: begin
                mul_req = 1'b1;
                mul_a   = y_r;
                mul_b   = dx_r;
                if (mul_ack) next_state = S_UPDATE;
            end
            S_UPDATE: begin
                next_state = (loop_more && !limit_hit) ? S_MUL0 : S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r    <= '0;
            dx_r   <= '0;
            u_r    <= '0;
            y_r    <= '0;
            a_r    <= '0;
            p0     <= '0;
            p1     <= '0;
            p2     <= '0;
            iter_r <= '0;
`ifdef DIFFEQ_ITER_LIMIT_EN
            err_r  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_r    <= x_in;
                        dx_r   <= dx_in;
                        u_r    <= u_in;
                        y_r    <= y_in;
                        a_r    <= a_in;
                        iter_r <= '0;
`ifdef DIFFEQ_ITER_LIMIT_EN
                        err_r  <= 1'b0;
`endif
                    end
                end
                S_MUL0: if (mul_ack) p0 <= prod;
                S_MUL1: if (mul_ack) p1 <= prod;
                S_MUL2: if (mul_ack) p2 <= prod;
                S_UPDATE: begin
                    x_r    <= x_next;
                    y_r    <= y_next;
                    u_r    <= u_next;
                    iter_r <= iter_next;
`ifdef DIFFEQ_ITER_LIMIT_EN
                    if (loop_more && limit_hit) err_r <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign x_out      = x_r;
    assign y_out      = y_r;
    assign u_out      = u_r;
    assign iter_count = iter_r;

endmodule

// File: tb/tb_diffeq_mul_sched.sv
// tb/tb_diffeq_mul_sched.sv - randomized self-checking bench for diffeq_mul_sched
module tb_diffeq_mul_sched;

    localparam int MAX_ITER = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] x_in, dx_in, u_in, y_in, a_in;
    logic        mul_req;
    logic [15:0] mul_a, mul_b;
    logic        mul_ack;
    logic [31:0] mul_p;
    logic        busy, done, err;
    logic [15:0] x_out, y_out, u_out;
    logic [7:0]  iter_count;

    int n_checks = 0;
    int n_fail   = 0;

    int          lat;
    int          wcnt;
    logic        spur;
    logic [15:0] prev_a, prev_b;
    int          req_seen;

    logic [31:0] exp_ops[$];
    logic [31:0] got_ops[$];
    logic [15:0] ex_x, ex_y, ex_u;
    int          ex_it;
    logic        ex_err;

    diffeq_mul_sched #(.WIDTH(16), .FRAC(0), .ITER_W(8), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .x_in(x_in), .dx_in(dx_in), .u_in(u_in), .y_in(y_in), .a_in(a_in),
        .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ack(mul_ack), .mul_p(mul_p),
        .busy(busy), .done(done),
        .x_out(x_out), .y_out(y_out), .u_out(u_out),
        .iter_count(iter_count), .err(err)
    );

    always #5 clk = ~clk;

    // Multiplier model: acks after lat wait cycles per operand set.
    assign mul_ack = (mul_req && (wcnt == lat)) || spur;
    assign mul_p   = {{16{mul_a[15]}}, mul_a} * {{16{mul_b[15]}}, mul_b};

    always @(posedge clk) begin
        if (!reset_n)                wcnt <= 0;
        else if (mul_req && !mul_ack) wcnt <= wcnt + 1;
        else                          wcnt <= 0;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && mul_req) begin
            req_seen <= req_seen + 1;
            if (wcnt != 0) check_eq("mul_stable", {mul_a, mul_b}, {prev_a, prev_b});
            if (mul_ack) got_ops.push_back({mul_a, mul_b});
        end
        prev_a <= mul_a;
        prev_b <= mul_b;
    end

    // Loop-level reference: the while loop itself with 16-bit wrapping arithmetic.
    task automatic ref_model(input logic [15:0] xi, dxi, ui, yi, ai);
        logic signed [15:0] x, dx, u, y, a, p0, p1, p2;
        x = xi; dx = dxi; u = ui; y = yi; a = ai;
        ex_it = 0; ex_err = 1'b0;
        exp_ops.delete();
        while (x < a) begin
            p0 = 16'(u * dx);  exp_ops.push_back({u, dx});
            p1 = 16'(x * p0);  exp_ops.push_back({x, p0});
            p2 = 16'(y * dx);  exp_ops.push_back({y, dx});
            u  = 16'(u - 16'sd3 * p1 - 16'sd3 * p2);
            y  = 16'(y + p0);
            x  = 16'(x + dx);
            ex_it++;
`ifdef DIFFEQ_ITER_LIMIT_EN
            if (ex_it == MAX_ITER && x < a) begin
                ex_err = 1'b1;
                break;
            end
`endif
        end
        ex_x = x; ex_y = y; ex_u = u;
    endtask

    task automatic run_case(input string tag, input logic [15:0] xi, dxi, ui, yi, ai,
                            input bit noise, input bit spur_first);
        int n;
        ref_model(xi, dxi, ui, yi, ai);
        if (spur_first) begin
            spur = 1'b1;
            @(negedge clk);
            spur = 1'b0;
        end
        got_ops.delete();
        req_seen = 0;
        x_in = xi; dx_in = dxi; u_in = ui; y_in = yi; a_in = ai;
        start = 1'b1;
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (done) begin
                start = 1'b0;
                break;
            end
            if (n > 5000) begin
                start = 1'b0;
                check_eq({tag, "_timeout"}, 64'(n), 64'(1 + ex_it * (3 * (lat + 1) + 1)));
                break;
            end
            start = noise ? 1'($urandom) : 1'b0;
            if (noise) x_in = 16'($urandom);
        end
        check_eq({tag, "_latency"}, 64'(n), 64'(1 + ex_it * (3 * (lat + 1) + 1)));
        check_eq({tag, "_x"}, x_out, ex_x);
        check_eq({tag, "_y"}, y_out, ex_y);
        check_eq({tag, "_u"}, u_out, ex_u);
        check_eq({tag, "_iter"}, iter_count, 64'(ex_it & 8'hff));
        check_eq({tag, "_err"}, err, ex_err);
        check_eq({tag, "_nops"}, 64'(got_ops.size()), 64'(exp_ops.size()));
        for (int i = 0; i < exp_ops.size() && i < got_ops.size(); i++)
            check_eq({tag, "_op"}, got_ops[i], exp_ops[i]);
        if (ex_it == 0) check_eq({tag, "_noreq"}, 64'(req_seen), 64'd0);
        @(negedge clk);
        check_eq({tag, "_idle"}, {done, busy}, 2'b00);
    endtask

    initial begin
        int k;
        reset_n = 1'b0; start = 1'b0; spur = 1'b0; lat = 0;
        x_in = '0; dx_in = '0; u_in = '0; y_in = '0; a_in = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_outs", {mul_req, mul_a, mul_b, busy, done, x_out, y_out, u_out, iter_count, err}, '0);
        reset_n = 1'b1;
        @(negedge clk);

        run_case("one_iter", 16'd0, 16'd1, 16'd1, 16'd0, 16'd1, 1'b0, 1'b0);
        check_eq("one_iter_u_const", u_out, 16'd1);
        run_case("two_iter", 16'd0, 16'd1, 16'd1, 16'd0, 16'd2, 1'b0, 1'b0);
        check_eq("two_iter_u_const", u_out, 16'hFFFB);
        run_case("zero_iter", 16'd5, 16'd3, 16'd7, 16'd9, 16'd5, 1'b0, 1'b0);
        lat = 3;
        run_case("stall_l3", 16'd0, 16'd1, 16'd1, 16'd0, 16'd2, 1'b1, 1'b1);

        // Reset while the second product of the first iteration is pending.
        x_in = 16'd0; dx_in = 16'd1; u_in = 16'd1; y_in = 16'd0; a_in = 16'd1;
        got_ops.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(got_ops.size() == 1 && mul_req) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("mid_mul1_reached", 64'(k < 100), 64'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_reset_outs", {mul_req, mul_a, mul_b, busy, done, x_out, y_out, u_out, iter_count, err}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_case("after_reset", 16'd0, 16'd1, 16'd1, 16'd0, 16'd1, 1'b0, 1'b0);

        lat = 1;
        run_case("limit", 16'd0, 16'd1, 16'd0, 16'd0, 16'd10, 1'b0, 1'b0);
`ifdef DIFFEQ_ITER_LIMIT_EN
        check_eq("limit_err_const", {err, iter_count, x_out}, {1'b1, 8'd3, 16'd3});
`else
        check_eq("limit_err_const", {err, iter_count, x_out}, {1'b0, 8'd10, 16'd10});
`endif

        for (int i = 0; i < 25; i++) begin
            logic [15:0] rx, rdx, ra;
            lat = int'($urandom_range(0, 3));
            rx  = 16'(int'($urandom_range(0, 40)) - 20);
            rdx = 16'($urandom_range(1, 8));
            if (i % 6 == 5) ra = 16'(rx - 16'($urandom_range(0, 10)));
            else            ra = 16'(rx + 16'($urandom_range(0, 30)));
            run_case("rand", rx, rdx, 16'($urandom), 16'($urandom), ra, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
